if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue, the successor to the single-register fetch stage. It holds the fetch PC, issues requests to a synchronous instruction memory (one-cycle read latency), buffers returned instructions with their PCs in a DEPTH-entry FIFO, and hands them to decode over a valid/ready handshake. Branch redirects support relative or absolute targets, flush the queue and squash the in-flight response.

## Interface
- PC_W, 24: width of PC, memory address and branch operands
- INSTR_W, 16: instruction width
- INSTR_BYTES, 4: PC increment per sequential fetch
- DEPTH, 4: queue entries; power of two, ≥2
- BR_ABS, 0: 0 = target is br_pc + br_offset; 1 = target is br_offset
- RESET_PC, 0: PC loaded on reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- br_taken  in  1  redirect request from EX
- br_offset  in  PC_W  branch offset (relative mode) or absolute target
- br_pc  in  PC_W  PC of the branching instruction (ignored when BR_ABS=1)
- freeze  in  1  suppress new memory requests
- imem_req  out  1  memory read request this cycle
- imem_addr  out  PC_W  read address (the current fetch PC)
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_req
- instr  out  INSTR_W  head-of-queue instruction
- instr_pc  out  PC_W  PC of instr
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decode accepts head this cycle
- fetch_count  out  32  performance counter (see Configuration)
- redirect_count  out  32  performance counter (see Configuration)

## Operation
- State: fetch_pc, inflight flag plus its PC, FIFO of {instr, pc} with rd/wr pointers and count (0..DEPTH).
- Request rule: imem_req = !rst && !freeze && !br_taken && (count + inflight) < DEPTH. imem_addr = fetch_pc regardless of imem_req.
- On request: fetch_pc += INSTR_BYTES (mod 2^PC_W), inflight set, request PC recorded.
- Response: in the cycle after a request, imem_rdata is written to the FIFO with the recorded PC unless squashed; inflight clears.
- Pop: instr_valid && instr_ready removes the head. Push and pop in the same cycle leave count unchanged. The request rule prevents overflow, including when the queue is full with a pop pending. The pop is not counted as free space until the next cycle.
- Redirect (br_taken in cycle N): target = BR_ABS ? br_offset : br_pc + br_offset (mod 2^PC_W).
  - fetch_pc ← target at the end of N.
  - FIFO is cleared.
  - A response arriving in N is discarded.
  - No request is issued in N.
  - A pop handshake in N is accepted, but the popped entry is architecturally dead.
- Redirect overrides freeze. fetch_pc loads even while frozen.
- freeze blocks requests only. An in-flight response is still stored, and decode pops continue.
- Reset values: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, imem_req=0, instr_valid=0, both counters=0. instr and instr_pc are don't-care while instr_valid=0.

## Timing
- Request-to-visible latency is 2 cycles: req in cycle N, data in N+1, instr_valid in N+2.
- After rst deasserts in cycle 0: req to RESET_PC in cycle 0, instr_valid in cycle 2.
- Redirect in N: first request to target in N+1; target instruction valid in N+3; instr_valid=0 in N+1 and N+2.
- Steady state with instr_ready=1, no freeze: one instruction per cycle.
- Reset asserted mid-operation: everything returns to reset values at the next edge, and any in-flight response is discarded.

## Configuration
- IF_PERF_EN defined:
  - fetch_count increments on every non-squashed response written to the queue.
  - redirect_count increments on every cycle with br_taken=1.
  - Both wrap at 2^32 and clear on rst.
- Not defined: both outputs are constant 0 and no counter flops are synthesised.

## Test plan
- Reset then stream (RESET_PC=0, instr_ready=1): imem_addr sequence 0,4,8,…; instr_pc 0 appears in cycle 2, then one new instruction per cycle.
- Backpressure (instr_ready=0 from reset): imem_req stops after 4 requests; count=4 and no overflow. Raising instr_ready gives PCs 0,4,8,12 in order, then fetching resumes at 16.
- Relative redirect (BR_ABS=0, br_pc=0x20, br_offset=0x100): queue flushes, the in-flight response is dropped, next imem_addr=0x120, instr_pc=0x120 three cycles after br_taken.
- Absolute redirect with wrap (BR_ABS=1, PC_W=24, br_offset=0xFFFFFC): fetches 0xFFFFFC then 0x000000.
- freeze high for 5 cycles with one request in flight: that instruction is still queued, no further imem_req, fetch_pc unchanged; br_taken during freeze still loads the target.
- IF_PERF_EN defined: 10 streamed fetches plus 2 redirects give fetch_count equal to responses stored (squashed ones excluded) and redirect_count=2; without the macro both read 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage with prefetch queue; IF_PERF_EN adds perf counters
module if_fetch_queue #(
  parameter int              PC_W        = 24,
  parameter int              INSTR_W     = 16,
  parameter int              INSTR_BYTES = 4,
  parameter int              DEPTH       = 4,
  parameter int              BR_ABS      = 0,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_offset,
  input  logic [PC_W-1:0]    br_pc,
  input  logic               freeze,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        fetch_count,
  output logic [31:0]        redirect_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    r_fetch_pc;
  logic               r_inflight;
  logic [PC_W-1:0]    r_inflight_pc;
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];
  logic [PC_W-1:0]    r_mem_pc    [DEPTH];
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;

  logic [CW-1:0]      w_occupancy;
  logic               w_req;
  logic               w_push;
  logic               w_pop;
  logic [PC_W-1:0]    w_target;

  // In-flight requests reserve a slot so a full queue can never be overrun,
  // and a pop this cycle is deliberately not treated as free space.
  assign w_occupancy = r_count + CW'(r_inflight);
  assign w_req       = !rst && !freeze && !br_taken && (w_occupancy < CW'(DEPTH));
  // A redirect squashes whatever response is arriving this cycle.
  assign w_push      = r_inflight && !br_taken;
  assign w_pop       = (r_count != '0) && instr_ready;
  assign w_target    = (BR_ABS != 0) ? br_offset : (br_pc + br_offset);

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign instr       = r_mem_instr[r_rd_ptr];
  assign instr_pc    = r_mem_pc[r_rd_ptr];
  assign instr_valid = (r_count != '0);

  // Fetch PC, in-flight tracking and queue pointers; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (br_taken) begin
        r_fetch_pc <= w_target;
      end else if (w_req) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(INSTR_BYTES);
      end
      r_inflight <= w_req;
      if (br_taken) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // PC of the outstanding request, paired with its data on return.
  always_ff @(posedge clk) begin
    if (w_req) r_inflight_pc <= r_fetch_pc;
  end

  // Queue storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_redirect_count;

  // Stored responses and redirect cycles, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count    <= '0;
      r_redirect_count <= '0;
    end else begin
      if (w_push)   r_fetch_count    <= r_fetch_count + 32'd1;
      if (br_taken) r_redirect_count <= r_redirect_count + 32'd1;
    end
  end

  assign fetch_count    = r_fetch_count;
  assign redirect_count = r_redirect_count;
`else
  assign fetch_count    = '0;
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue (relative and absolute redirect instances)
module tb_if_fetch_queue;
  localparam int PC_W    = 24;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic br_taken = 1'b0;
  logic freeze = 1'b0;
  logic instr_ready = 1'b0;
  logic [PC_W-1:0] br_offset = '0;
  logic [PC_W-1:0] br_pc = '0;

  logic               imem_req, a_req;
  logic [PC_W-1:0]    imem_addr, a_addr;
  logic [INSTR_W-1:0] rd_r, rd_a;
  logic [INSTR_W-1:0] instr, a_instr;
  logic [PC_W-1:0]    instr_pc, a_instr_pc;
  logic               instr_valid, a_valid;
  logic [31:0]        fetch_count, redirect_count, a_fcount, a_rcount;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ins;
    int                 cyc;
  } ent_t;

  ent_t            q[$];
  logic [PC_W-1:0] m_pc = '0;
  int              cyc = 0;
  int              m_fetch = 0;
  int              m_redir = 0;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_f(input logic [PC_W-1:0] a);
    return a[17:2] ^ 16'hC3A5;
  endfunction

  always @(posedge clk) rd_r <= mem_f(imem_addr);
  always @(posedge clk) rd_a <= mem_f(a_addr);

  if_fetch_queue #(.BR_ABS(0)) u_rel (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_offset(br_offset), .br_pc(br_pc),
    .freeze(freeze), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(rd_r),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_count(fetch_count), .redirect_count(redirect_count)
  );

  if_fetch_queue #(.BR_ABS(1)) u_abs (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_offset(br_offset), .br_pc(br_pc),
    .freeze(freeze), .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(rd_a),
    .instr(a_instr), .instr_pc(a_instr_pc), .instr_valid(a_valid), .instr_ready(instr_ready),
    .fetch_count(a_fcount), .redirect_count(a_rcount)
  );

  // Scoreboard step: predicts this cycle from the model, compares, then advances one clock.
  task automatic advance();
    bit e_req, e_valid, pop;
    #1;
    e_req   = !rst && !freeze && !br_taken && (q.size() < DEPTH);
    e_valid = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
    pop     = e_valid && instr_ready;
    if (!rst) begin
      checks++;
      if (imem_req !== e_req) begin
        errors++; $display("FAIL sb_req cyc=%0d got %b exp %b", cyc, imem_req, e_req);
      end
      if (e_req) begin
        checks++;
        if (imem_addr !== m_pc) begin
          errors++; $display("FAIL sb_addr cyc=%0d got %h exp %h", cyc, imem_addr, m_pc);
        end
      end
      checks++;
      if (instr_valid !== e_valid) begin
        errors++; $display("FAIL sb_valid cyc=%0d got %b exp %b", cyc, instr_valid, e_valid);
      end
      if (pop) begin
        checks++;
        if (instr_pc !== q[0].pc || instr !== q[0].ins) begin
          errors++; $display("FAIL sb_pop cyc=%0d got pc %h ins %h exp pc %h ins %h",
                             cyc, instr_pc, instr, q[0].pc, q[0].ins);
        end
      end
    end
    if (rst) begin
      q.delete(); m_pc = '0; m_fetch = 0; m_redir = 0;
    end else begin
      if (q.size() > 0 && q[$].cyc == cyc - 1 && !br_taken) m_fetch++;
      if (br_taken) begin
        q.delete(); m_pc = br_pc + br_offset; m_redir++;
      end else begin
        if (pop) void'(q.pop_front());
        if (e_req) begin
          q.push_back('{m_pc, mem_f(m_pc), cyc});
          m_pc = m_pc + 24'd4;
        end
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; instr_ready = 1'b0;
    repeat (3) advance();
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags got req %b valid %b exp 0 0", imem_req, instr_valid);
    end
    checks++;
    if (imem_addr !== 24'h0 || a_addr !== 24'h0) begin
      errors++; $display("FAIL reset_pc got %h/%h exp 0", imem_addr, a_addr);
    end
    checks++;
    if (fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0", fetch_count, redirect_count);
    end
  endtask

  task automatic test_stream();
    rst = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i == 0) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 24'h0) begin
          errors++; $display("FAIL stream_first_req got %b %h exp 1 0", imem_req, imem_addr);
        end
      end
      if (i >= 2) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 24'((i - 2) * 4)) begin
          errors++; $display("FAIL stream_pc i=%0d got %b %h exp 1 %h", i, instr_valid, instr_pc, (i - 2) * 4);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    rst = 1'b1; advance();
    rst = 1'b0; instr_ready = 1'b0; nreq = 0;
    for (int i = 0; i < 8; i++) begin
      #1; if (imem_req === 1'b1) nreq++;
      advance();
    end
    checks++;
    if (nreq != 4 || instr_valid !== 1'b1) begin
      errors++; $display("FAIL bp_full got reqs %0d valid %b exp 4 1", nreq, instr_valid);
    end
    instr_ready = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b0 || instr_pc !== 24'h0) begin
      errors++; $display("FAIL bp_release got req %b pc %h exp 0 0", imem_req, instr_pc);
    end
    advance(); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 24'h10) begin
      errors++; $display("FAIL bp_resume got %b %h exp 1 10", imem_req, imem_addr);
    end
    repeat (6) advance();
  endtask

  task automatic test_redirect_rel();
    repeat (2) advance();
    br_taken = 1'b1; br_pc = 24'h20; br_offset = 24'h100; #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rel_noreq got %b exp 0", imem_req);
    end
    advance(); br_taken = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 24'h120 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rel_n1 got %b %h %b exp 1 120 0", imem_req, imem_addr, instr_valid);
    end
    checks++;
    if (a_addr !== 24'h100) begin
      errors++; $display("FAIL abs_target got %h exp 100", a_addr);
    end
    advance(); #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL rel_n2 got valid %b exp 0", instr_valid);
    end
    advance(); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 24'h120 || instr !== mem_f(24'h120)) begin
      errors++; $display("FAIL rel_n3 got %b %h %h exp 1 120 %h", instr_valid, instr_pc, instr, mem_f(24'h120));
    end
    repeat (3) advance();
  endtask

  task automatic test_abs_wrap();
    br_taken = 1'b1; br_pc = 24'h40; br_offset = 24'hFFFFFC;
    advance(); br_taken = 1'b0; #1;
    checks++;
    if (a_req !== 1'b1 || a_addr !== 24'hFFFFFC) begin
      errors++; $display("FAIL wrap_n1 got %b %h exp 1 fffffc", a_req, a_addr);
    end
    advance(); #1;
    checks++;
    if (a_req !== 1'b1 || a_addr !== 24'h000000) begin
      errors++; $display("FAIL wrap_n2 got %b %h exp 1 000000", a_req, a_addr);
    end
    advance(); #1;
    checks++;
    if (a_valid !== 1'b1 || a_instr_pc !== 24'hFFFFFC || a_instr !== mem_f(24'hFFFFFC)) begin
      errors++; $display("FAIL wrap_n3 got %b %h %h exp 1 fffffc %h", a_valid, a_instr_pc, a_instr, mem_f(24'hFFFFFC));
    end
    advance(); #1;
    checks++;
    if (a_valid !== 1'b1 || a_instr_pc !== 24'h0) begin
      errors++; $display("FAIL wrap_n4 got %b %h exp 1 000000", a_valid, a_instr_pc);
    end
    repeat (2) advance();
  endtask

  task automatic test_freeze();
    rst = 1'b1; advance();
    rst = 1'b0; instr_ready = 1'b0; freeze = 1'b0;
    advance();
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 24'h4) begin
        errors++; $display("FAIL frz_hold i=%0d got %b %h exp 0 4", i, imem_req, imem_addr);
      end
      if (i >= 1) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 24'h0) begin
          errors++; $display("FAIL frz_stored i=%0d got %b %h exp 1 0", i, instr_valid, instr_pc);
        end
      end
      advance();
    end
    br_taken = 1'b1; br_pc = 24'h0; br_offset = 24'h200;
    advance(); br_taken = 1'b0; #1;
    checks++;
    if (imem_addr !== 24'h200 || a_addr !== 24'h200 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL frz_redirect got %h %h %b %b exp 200 200 0 0", imem_addr, a_addr, imem_req, instr_valid);
    end
    advance();
    freeze = 1'b0; instr_ready = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 24'h200) begin
      errors++; $display("FAIL frz_release got %b %h exp 1 200", imem_req, imem_addr);
    end
    repeat (4) advance();
  endtask

  task automatic test_mid_reset();
    repeat (3) advance();
    rst = 1'b1; advance();
    rst = 1'b0; #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 24'h0) begin
      errors++; $display("FAIL midrst got %b %b %h exp 0 1 0", instr_valid, imem_req, imem_addr);
    end
    checks++;
    if (fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
      errors++; $display("FAIL midrst_cnt got %0d %0d exp 0 0", fetch_count, redirect_count);
    end
    repeat (4) advance();
  endtask

  task automatic test_perf();
    int exp_f, exp_r;
    rst = 1'b1; advance();
    rst = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      br_taken = (i == 4 || i == 8);
      br_pc = 24'h0;
      br_offset = (i == 4) ? 24'h80 : 24'h300;
      advance();
    end
    br_taken = 1'b0;
    advance();
`ifdef IF_PERF_EN
    exp_f = m_fetch; exp_r = m_redir;
`else
    exp_f = 0; exp_r = 0;
`endif
    #1;
    checks++;
    if (fetch_count !== 32'(exp_f)) begin
      errors++; $display("FAIL perf_fetch got %0d exp %0d", fetch_count, exp_f);
    end
    checks++;
    if (redirect_count !== 32'(exp_r)) begin
      errors++; $display("FAIL perf_redirect got %0d exp %0d", redirect_count, exp_r);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_rel();
    test_abs_wrap();
    test_freeze();
    test_mid_reset();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
